instr_fetch_unit: RTL and testbench

//   Fetches 32-bit RV32I instructions from instruction memory and feeds the decode/control stage.

---
 rtl/instr_fetch_unit_if.sv | 33 +++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory req/ack port, redirect input and decode-side valid/ready head.
// master = fetch unit, slave = memory/decode/branch environment.
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic [6:0]      opcode;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, opcode,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, opcode,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential RV32I fetcher with a 2-entry in-order buffer; first instr_valid 2 cycles after reset on zero-wait memory.
// Fetching pauses while both buffer slots are occupied; redirects flush the buffer and drain any in-flight request.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master ifu
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STALL, S_FLUSH} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [1:0]      cnt_q, cnt_d;
  entry_t          head_q, head_d;
  entry_t          tail_q, tail_d;

  logic            imem_req;
  logic            ack;
  logic            pending;
  logic            push;
  logic            pop;
  logic            redir;
  logic [XLEN-1:0] redir_pc;
  entry_t          fetched;

  assign redir    = ifu.redirect_valid;
  assign redir_pc = ifu.redirect_pc & ~XLEN'(3);
  assign ack      = imem_req & ifu.imem_ack;
  assign pending  = imem_req & ~ifu.imem_ack;
  assign push     = ack & (state_q == S_REQ) & ~redir;
  assign pop      = (cnt_q != 2'd0) & ifu.instr_ready & ~redir;
  assign fetched  = '{instr: ifu.imem_rdata, pc: pc_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (cnt_q == 2'd2) state_d = S_STALL;
      S_STALL: if (cnt_q != 2'd2) state_d = S_REQ;
      S_FLUSH: if (ack) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
    // A request already on the bus must complete before the new stream can start.
    if (redir) state_d = pending ? S_FLUSH : S_REQ;
  end

  // Slot occupancy is judged on the registered count, so a same-cycle pop never opens a request.
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      S_REQ:   imem_req = (cnt_q != 2'd2);
      S_FLUSH: imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    tgt_d = tgt_q;
    if (push) pc_d = pc_q + XLEN'(4);
    if ((state_q == S_FLUSH) && ack) pc_d = tgt_q;
    if (redir) begin
      if (pending) tgt_d = redir_pc;
      else         pc_d  = redir_pc;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) head_d = fetched;
      else               tail_d = fetched;
      cnt_d = cnt_d + 2'd1;
    end
    if (redir) cnt_d = 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      tgt_q  <= RESET_PC;
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      pc_q   <= pc_d;
      tgt_q  <= tgt_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign ifu.imem_req    = imem_req;
  assign ifu.imem_addr   = pc_q;
  assign ifu.instr_valid = (cnt_q != 2'd0);
  assign ifu.instr       = head_q.instr;
  assign ifu.instr_pc    = head_q.pc;
  assign ifu.opcode      = head_q.instr[6:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: variable-latency memory model plus an in-order PC-stream scoreboard.
module tb_instr_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) bus();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .ifu (bus.master)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_lat = 0;
  int          lat_cur = 0;
  int          wait_cnt = 0;
  int          ack_cnt = 0;
  int          pops = 0;
  bit          pend = 1'b0;
  bit          redir_prev = 1'b0;
  bit          found;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_pc = RESET_PC;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge: answers the memory port, scores this cycle's handshakes, advances one clock.
  task automatic tick();
    logic [31:0] w;
    bus.imem_ack = 1'b0;
    if (rst || !bus.imem_req) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("addr_held", bus.imem_addr, pend_addr);
      end else begin
        lat_cur   = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
        wait_cnt  = 0;
        pend_addr = bus.imem_addr;
      end
      if (wait_cnt >= lat_cur) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memf(bus.imem_addr);
        pend = 1'b0;
        ack_cnt++;
      end else begin
        wait_cnt++;
        pend = 1'b1;
      end
    end
    if (!rst) begin
      if (redir_prev) check("valid_after_redirect", 32'(bus.instr_valid), 32'd0);
      redir_prev = bus.redirect_valid;
      if (bus.redirect_valid) begin
        exp_pc = bus.redirect_pc & ~32'd3;
      end else if (bus.instr_valid && bus.instr_ready) begin
        w = memf(exp_pc);
        check("head_pc", bus.instr_pc, exp_pc);
        check("head_instr", bus.instr, w);
        check("opcode", 32'(bus.opcode), 32'(w[6:0]));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.redirect_valid = 1'b0;
    pend = 1'b0;
    redir_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = RESET_PC;
  endtask

  task automatic redirect_when_req(input logic [31:0] target);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_req && !pend) found = 1'b1;
      else tick();
    end
    check("req_before_redirect", 32'(found), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, RESET_PC);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_instr_pc", bus.instr_pc, 32'd0);
    check("rst_opcode", 32'(bus.opcode), 32'd0);

    // Zero-wait memory: latency and sustained rate
    rst = 1'b0;
    exp_pc = RESET_PC;
    tick();
    check("lat_valid_c1", 32'(bus.instr_valid), 32'd0);
    check("lat_req_c1", 32'(bus.imem_req), 32'd1);
    check("lat_addr_c1", bus.imem_addr, RESET_PC);
    tick();
    check("lat_valid_c2", 32'(bus.instr_valid), 32'd1);
    check("lat_pc_c2", bus.instr_pc, RESET_PC);
    pops = 0;
    repeat (8) tick();
    check("throughput_pops", pops, 8);

    // Decode stalled: buffer fills with exactly two entries
    do_reset();
    bus.instr_ready = 1'b0;
    ack_cnt = 0;
    repeat (7) tick();
    check("full_acks", ack_cnt, 2);
    check("full_req_low", 32'(bus.imem_req), 32'd0);
    check("full_valid", 32'(bus.instr_valid), 32'd1);
    check("full_head_pc", bus.instr_pc, 32'h0);
    bus.instr_ready = 1'b1;
    repeat (6) tick();

    // Three-cycle memory latency
    mem_lat = 2;
    repeat (10) tick();
    ack_cnt = 0;
    repeat (30) tick();
    check("slow_mem_rate", ack_cnt, 10);

    // Redirect while the fetch of 0x8 is still waiting
    do_reset();
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.imem_req && bus.imem_addr == 32'h8 && !pend) found = 1'b1;
      else tick();
    end
    check("reach_addr_8", 32'(found), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    check("flush_addr_held", bus.imem_addr, 32'h8);
    check("flush_req", 32'(bus.imem_req), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (bus.imem_req && bus.imem_addr == 32'h100) found = 1'b1;
      else tick();
    end
    check("redirect_target_fetched", 32'(found), 32'd1);
    repeat (10) tick();

    // Redirect coinciding with an ack
    mem_lat = 0;
    repeat (6) tick();
    redirect_when_req(32'h200);
    check("ack_redir_addr", bus.imem_addr, 32'h200);
    check("ack_redir_req", 32'(bus.imem_req), 32'd1);
    repeat (4) tick();

    // Misaligned redirect and address wrap
    redirect_when_req(32'hFFFF_FFFE);
    check("wrap_aligned", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_next", bus.imem_addr, 32'h0);
    repeat (4) tick();

    // Asynchronous reset mid-request
    mem_lat = 3;
    bus.instr_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.instr_valid && bus.imem_req && pend) found = 1'b1;
      else tick();
    end
    check("midreq_setup", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_req_drop", 32'(bus.imem_req), 32'd0);
    check("async_valid_drop", 32'(bus.instr_valid), 32'd0);
    check("async_addr", bus.imem_addr, RESET_PC);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = RESET_PC;
    pend = 1'b0;
    redir_prev = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    check("restart_req", 32'(bus.imem_req), 32'd1);
    check("restart_addr", bus.imem_addr, RESET_PC);
    repeat (10) tick();

    // Randomized traffic: latency, decode stalls and redirects
    do_reset();
    mem_lat = -1;
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      bus.instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      end
      tick();
    end
    check("random_progress", 32'(pops > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
